// File: rtl/uart_tx_queue.sv
// CPU-side front end for the RAM1/UART port: address decode, UART transmit FIFO
// and an idle-cycle drain engine. Define UART_TXQ_TIMEOUT_EN to bound the WBUSY wait.
module uart_tx_queue #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] mem_addr_i,
  input  logic [15:0] mem_data_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  output logic [15:0] mem_rdata_o,
  output logic        stall_o,
  input  logic        data_ready_i,
  input  logic        tbre_i,
  input  logic        tsre_i,
  output logic        is_RAM1_o,
  output logic        is_UART_o,
  output logic [17:0] addr_o,
  output logic [15:0] data_o,
  output logic        isread_o,
  output logic        iswrite_o,
  input  logic [15:0] ram1res_i,
  output logic [AW:0] txq_level_o
);

  if (AW != $clog2(DEPTH) || TIMEOUT < 2) begin : g_param_check
    $error("uart_tx_queue: AW must equal log2(DEPTH) and TIMEOUT must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, DRAIN, WBUSY, WDONE} state_t;

  state_t        state, state_nxt;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          full, empty;
  logic          sel_data, sel_stat, cpu_req, q_wr, fwd, push, pop, wr_stall;

  assign sel_data    = (mem_addr_i[15:0] == 16'hBF00);
  assign sel_stat    = (mem_addr_i[15:0] == 16'hBF01);
  assign cpu_req     = mem_rd_i | mem_wr_i;
  assign q_wr        = mem_wr_i & sel_data;
  // Accesses that need the downstream bus: RAM1 traffic and UART data reads.
  assign fwd         = cpu_req & ~q_wr & ~sel_stat;
  assign full        = (level == (AW+1)'(DEPTH));
  assign empty       = (level == '0);
  assign pop         = (state == DRAIN);
  assign wr_stall    = q_wr & full & ~pop;
  assign push        = q_wr & ~wr_stall;
  assign txq_level_o = level;

`ifdef UART_TXQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  // Holds the number of cycles since the drain write while in WBUSY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (state == DRAIN) begin
      to_cnt <= TW'(1);
    end else if (state == WBUSY) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage has no reset; validity is tracked solely by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= mem_data_i;
  end

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    state_nxt   = state;
    stall_o     = wr_stall;
    mem_rdata_o = '0;
    is_RAM1_o   = 1'b0;
    is_UART_o   = 1'b0;
    addr_o      = '0;
    data_o      = '0;
    isread_o    = 1'b0;
    iswrite_o   = 1'b0;

    if (pop) begin
      is_UART_o = 1'b1;
      addr_o    = 18'h0BF00;
      data_o    = mem[rd_ptr];
      iswrite_o = 1'b1;
      if (fwd) stall_o = 1'b1;
    end else if (fwd) begin
      is_RAM1_o   = ~sel_data;
      is_UART_o   = sel_data;
      addr_o      = mem_addr_i;
      data_o      = mem_data_i;
      isread_o    = mem_rd_i;
      iswrite_o   = mem_wr_i;
      mem_rdata_o = ram1res_i;
    end

    if (mem_rd_i & sel_stat) mem_rdata_o = {14'b0, data_ready_i, ~full};

    case (state)
      // A stalled queue write does not count as bus activity, or a full FIFO would deadlock.
      IDLE:  if (!empty && tbre_i && tsre_i && !(cpu_req && !stall_o)) state_nxt = DRAIN;
      DRAIN: state_nxt = WBUSY;
      WBUSY: begin
        if (!tbre_i) state_nxt = WDONE;
`ifdef UART_TXQ_TIMEOUT_EN
        else if (to_cnt == TW'(TIMEOUT - 1)) state_nxt = WDONE;
`endif
      end
      WDONE: if (tbre_i && tsre_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: a UART model acknowledges drain writes and a
// scoreboard queue holds the bytes the CPU has queued, in expected drain order.
module tb_uart_tx_queue;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [17:0] mem_addr_i = '0;
  logic [15:0] mem_data_i = '0;
  logic        mem_rd_i = 1'b0;
  logic        mem_wr_i = 1'b0;
  logic [15:0] mem_rdata_o;
  logic        stall_o;
  logic        data_ready_i = 1'b0;
  logic        tbre_i = 1'b1;
  logic        tsre_i = 1'b1;
  logic        is_RAM1_o, is_UART_o;
  logic [17:0] addr_o;
  logic [15:0] data_o;
  logic        isread_o, iswrite_o;
  logic [15:0] ram1res_i = '0;
  logic [AW:0] txq_level_o;

  uart_tx_queue #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i),
    .mem_rdata_o(mem_rdata_o), .stall_o(stall_o),
    .data_ready_i(data_ready_i), .tbre_i(tbre_i), .tsre_i(tsre_i),
    .is_RAM1_o(is_RAM1_o), .is_UART_o(is_UART_o),
    .addr_o(addr_o), .data_o(data_o),
    .isread_o(isread_o), .iswrite_o(iswrite_o),
    .ram1res_i(ram1res_i), .txq_level_o(txq_level_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb_q[$];
  int          drain_cnt = 0;
  int          busy = 0;
  bit          hold_low = 1'b0;
  bit          no_ack = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART model and drain monitor: tbre drops for two cycles after each drain write.
  always @(negedge clk) begin
    if (rst && iswrite_o && is_UART_o) begin
      drain_cnt++;
      check("drain_addr", 32'(addr_o), 32'h0BF00);
      check("drain_expected", 32'(sb_q.size() > 0), 32'h1);
      if (sb_q.size() > 0) check("drain_data", 32'(data_o), 32'(sb_q.pop_front()));
      busy = 2;
    end else if (busy > 0) begin
      busy--;
    end
    tbre_i = hold_low ? 1'b0 : (no_ack ? 1'b1 : (busy == 0));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle();
    mem_rd_i   = 1'b0;
    mem_wr_i   = 1'b0;
    mem_addr_i = '0;
    mem_data_i = '0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic q_write(input logic [15:0] d, input int budget, output int stalls);
    mem_addr_i = 18'h0BF00;
    mem_data_i = d;
    mem_wr_i   = 1'b1;
    mem_rd_i   = 1'b0;
    stalls     = 0;
    @(negedge clk);
    while (stall_o && stalls < budget) begin
      stalls++;
      next();
      @(negedge clk);
    end
    if (stall_o) check("write_timeout", 32'(stall_o), 32'h0);
    else sb_q.push_back(d);
    next();
  endtask

  task automatic wait_drains(input int target, input int budget);
    int n = 0;
    while (drain_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_count", 32'(drain_cnt), 32'(target));
  endtask

  int s;

  initial begin
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_level", 32'(txq_level_o), 32'h0);
    check("rst_stall", 32'(stall_o), 32'h0);
    check("rst_strobes", 32'({is_RAM1_o, is_UART_o, isread_o, iswrite_o}), 32'h0);
    check("rst_rdata", 32'(mem_rdata_o), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    next();

    // Three back-to-back queued bytes, drained in order.
    q_write(16'h0041, 4, s); check("t1_stall_41", 32'(s), 32'h0);
    q_write(16'h0042, 4, s); check("t1_stall_42", 32'(s), 32'h0);
    q_write(16'h0043, 4, s); check("t1_stall_43", 32'(s), 32'h0);
    idle();
    @(negedge clk);
    check("t1_level3", 32'(txq_level_o), 32'h3);
    wait_drains(3, 100);
    repeat (5) @(negedge clk);
    check("t1_level0", 32'(txq_level_o), 32'h0);
    check("t1_sb_empty", 32'(sb_q.size()), 32'h0);

    // Fill with the UART busy, then overflow by one.
    next();
    hold_low = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      q_write(16'h0010 + 16'(i), 4, s);
      check("t2_fill_stall", 32'(s), 32'h0);
    end
    idle();
    @(negedge clk);
    check("t2_level_full", 32'(txq_level_o), 32'(DEPTH));
    next();
    mem_addr_i = 18'h0BF00; mem_data_i = 16'h0018; mem_wr_i = 1'b1;
    @(negedge clk);
    check("t2_ninth_stall", 32'(stall_o), 32'h1);
    next();
    idle();
    mem_addr_i = 18'h0BF01; mem_rd_i = 1'b1;
    @(negedge clk);
    check("t2_status_full", 32'(mem_rdata_o), 32'h0000);
    check("t2_status_stall", 32'(stall_o), 32'h0);
    next();
    data_ready_i = 1'b1;
    @(negedge clk);
    check("t2_status_dr", 32'(mem_rdata_o), 32'h0002);
    next();
    idle();
    data_ready_i = 1'b0;

    // Release the UART; the held write lands in the DRAIN cycle.
    hold_low = 1'b0;
    q_write(16'h0018, 20, s);
    check("t3_was_stalled", 32'(s > 0), 32'h1);
    idle();
    @(negedge clk);
    check("t3_level_kept", 32'(txq_level_o), 32'(DEPTH));
    wait_drains(3 + DEPTH + 1, 400);
    repeat (5) @(negedge clk);
    check("t3_level0", 32'(txq_level_o), 32'h0);
    check("t3_sb_empty", 32'(sb_q.size()), 32'h0);

    // RAM1 read takes priority over a pending drain.
    next();
    q_write(16'h0055, 4, s);
    mem_wr_i = 1'b0; mem_rd_i = 1'b1; mem_addr_i = 18'h01234; ram1res_i = 16'hBEEF;
    @(negedge clk);
    check("t4_is_ram1", 32'(is_RAM1_o), 32'h1);
    check("t4_is_uart", 32'(is_UART_o), 32'h0);
    check("t4_addr", 32'(addr_o), 32'h01234);
    check("t4_isread", 32'(isread_o), 32'h1);
    check("t4_no_write", 32'(iswrite_o), 32'h0);
    check("t4_rdata", 32'(mem_rdata_o), 32'hBEEF);
    check("t4_stall", 32'(stall_o), 32'h0);
    next();
    idle();
    @(negedge clk);
    check("t4_no_drain_yet", 32'(iswrite_o), 32'h0);
    check("t4_level1", 32'(txq_level_o), 32'h1);
    next();
    @(negedge clk);
    check("t4_drain_now", 32'({is_UART_o, iswrite_o}), 32'h3);
    wait_drains(3 + DEPTH + 2, 50);
    repeat (6) @(negedge clk);

    // Direct forwarding of a RAM1 write and a UART data read.
    next();
    mem_addr_i = 18'h2ABCD; mem_data_i = 16'h1357; mem_wr_i = 1'b1;
    @(negedge clk);
    check("fw_wr_sel", 32'({is_RAM1_o, is_UART_o, isread_o, iswrite_o}), 32'h9);
    check("fw_wr_addr", 32'(addr_o), 32'h2ABCD);
    check("fw_wr_data", 32'(data_o), 32'h1357);
    next();
    mem_wr_i = 1'b0; mem_rd_i = 1'b1; mem_addr_i = 18'h0BF00; ram1res_i = 16'h00A5;
    @(negedge clk);
    check("fw_urd_sel", 32'({is_RAM1_o, is_UART_o, isread_o, iswrite_o}), 32'h6);
    check("fw_urd_rdata", 32'(mem_rdata_o), 32'h00A5);
    next();
    mem_addr_i = 18'h0BF01; data_ready_i = 1'b1;
    @(negedge clk);
    check("status_empty", 32'(mem_rdata_o), 32'h0003);
    check("status_local", 32'({is_RAM1_o, is_UART_o, isread_o}), 32'h0);
    next();
    idle();
    data_ready_i = 1'b0;

    // Reset while stuck in WBUSY with four bytes still queued.
    no_ack = 1'b1;
    for (int i = 0; i < 5; i++) q_write(16'h0060 + 16'(i), 4, s);
    idle();
    wait_drains(3 + DEPTH + 3, 20);
    repeat (10) @(negedge clk);
    check("t5_level4", 32'(txq_level_o), 32'h4);
    check("t5_stuck", 32'(drain_cnt), 32'(3 + DEPTH + 3));
    #2 rst = 1'b0;
    #1;
    check("t5_rst_level", 32'(txq_level_o), 32'h0);
    check("t5_rst_write", 32'(iswrite_o), 32'h0);
    check("t5_rst_stall", 32'(stall_o), 32'h0);
    check("t5_rst_rdata", 32'(mem_rdata_o), 32'h0);
    sb_q.delete();
    no_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (30) @(negedge clk);
    check("t5_no_more_drain", 32'(drain_cnt), 32'(3 + DEPTH + 3));
    check("t5_level_after", 32'(txq_level_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
